// File: rtl/m_seq_pkg.sv
// ---------------------------------------------------------------------------
// m_seq_pkg: shared PRBS15 constants, FSM encoding and LFSR step. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
package m_seq_pkg;
  localparam int LFSR_LEN = 15;
  // x^15 + x^14 + 1: feedback from the two oldest stages
  localparam int TAP_HI   = 14;
  localparam int TAP_LO   = 13;
  localparam int WIN_LEN  = 16;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  function automatic logic [LFSR_LEN-1:0] lfsr_step(input logic [LFSR_LEN-1:0] s);
    return {s[LFSR_LEN-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction
endpackage
`default_nettype wire

// File: rtl/m_seq_next_word.sv
// ---------------------------------------------------------------------------
// m_seq_next_word: advances the LFSR STEPS times, emitting bits MSB first. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module m_seq_next_word
  import m_seq_pkg::*;
#(
  parameter int STEPS = 32
) (
  input  logic [LFSR_LEN-1:0] i_state,
  output logic [STEPS-1:0]    o_word,
  output logic [LFSR_LEN-1:0] o_next_state
);
  logic [LFSR_LEN-1:0] state_v;

  always_comb begin
    state_v = i_state;
    o_word  = '0;
    for (int i = 0; i < STEPS; i++) begin
      state_v             = lfsr_step(state_v);
      o_word[STEPS-1-i]   = state_v[0];
    end
    o_next_state = state_v;
  end
endmodule
`default_nettype wire

// File: rtl/m_seq_checker.sv
// ---------------------------------------------------------------------------
// m_seq_checker: PRBS15 receive checker with hunt/verify/lock FSM and stats. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module m_seq_checker
  import m_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int LOCK_CNT    = 4,
  parameter int LOSS_THRESH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Signal_Recv,
  input  logic                  recv_valid,
  input  logic                  clr_cnt,
  output logic                  locked,
  output logic                  err_valid,
  output logic [5:0]            err_bits,
  output logic [31:0]           err_total,
  output logic [31:0]           word_total
);
  localparam int          CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam int          GOOD_W   = $clog2(LOCK_CNT + 1);
  localparam int          SUM_W    = $clog2(WIN_LEN * DATA_WIDTH + 1);
  localparam int          WCNT_W   = $clog2(WIN_LEN);
  localparam logic [31:0] THRESH_U = 32'(LOSS_THRESH);

  state_e              state_q, state_d;
  logic [LFSR_LEN-1:0] lfsr_q, lfsr_d, lfsr_adv, seed;
  logic [DATA_WIDTH-1:0] pred_word, diff;
  logic [CNT_W-1:0]    err_cnt;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [SUM_W-1:0]    win_sum_q, win_sum_d, sum_next;
  logic [WCNT_W-1:0]   win_cnt_q, win_cnt_d;
  logic                locked_q, locked_d, err_valid_q, err_valid_d;
  logic [5:0]          err_bits_q, err_bits_d;
  logic [31:0]         err_total_q, err_total_d, word_total_q, word_total_d;
  logic [32:0]         err_sum;

  m_seq_next_word #(.STEPS(DATA_WIDTH)) u_next_word (
    .i_state      (lfsr_q),
    .o_word       (pred_word),
    .o_next_state (lfsr_adv)
  );

  assign diff     = Signal_Recv ^ pred_word;
  assign seed     = Signal_Recv[LFSR_LEN-1:0];
  assign sum_next = win_sum_q + SUM_W'(err_cnt);
  assign err_sum  = {1'b0, err_total_q} + 33'(err_cnt);

  always_comb begin
    err_cnt = '0;
    for (int i = 0; i < DATA_WIDTH; i++) err_cnt = err_cnt + CNT_W'(diff[i]);
  end

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    good_d       = good_q;
    win_sum_d    = win_sum_q;
    win_cnt_d    = win_cnt_q;
    locked_d     = locked_q;
    err_valid_d  = 1'b0;
    err_bits_d   = err_bits_q;
    err_total_d  = err_total_q;
    word_total_d = word_total_q;

    if (recv_valid) begin
      case (state_q)
        ST_HUNT: begin
          // An all-zero seed would lock the LFSR up, so such words are ignored
          if (seed != '0) begin
            lfsr_d  = seed;
            good_d  = '0;
            state_d = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          err_valid_d = 1'b1;
          err_bits_d  = 6'(err_cnt);
          if (err_cnt == '0) begin
            lfsr_d = lfsr_adv;
            if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
              state_d   = ST_LOCKED;
              locked_d  = 1'b1;
              good_d    = '0;
              win_sum_d = '0;
              win_cnt_d = '0;
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end else begin
            // Fall back to hunting, reusing the failing word as the new seed
            good_d = '0;
            lfsr_d = seed;
            if (seed == '0) state_d = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          err_valid_d  = 1'b1;
          err_bits_d   = 6'(err_cnt);
          lfsr_d       = lfsr_adv;
          word_total_d = (word_total_q == '1) ? '1 : word_total_q + 32'd1;
          err_total_d  = err_sum[32] ? '1 : err_sum[31:0];
          if (32'(sum_next) >= THRESH_U) begin
            state_d   = ST_HUNT;
            locked_d  = 1'b0;
            win_sum_d = '0;
            win_cnt_d = '0;
          end else if (win_cnt_q == WCNT_W'(WIN_LEN - 1)) begin
            win_sum_d = '0;
            win_cnt_d = '0;
          end else begin
            win_sum_d = sum_next;
            win_cnt_d = win_cnt_q + WCNT_W'(1);
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (clr_cnt) begin
      err_total_d  = '0;
      word_total_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      lfsr_q       <= '0;
      good_q       <= '0;
      win_sum_q    <= '0;
      win_cnt_q    <= '0;
      locked_q     <= 1'b0;
      err_valid_q  <= 1'b0;
      err_bits_q   <= '0;
      err_total_q  <= '0;
      word_total_q <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      good_q       <= good_d;
      win_sum_q    <= win_sum_d;
      win_cnt_q    <= win_cnt_d;
      locked_q     <= locked_d;
      err_valid_q  <= err_valid_d;
      err_bits_q   <= err_bits_d;
      err_total_q  <= err_total_d;
      word_total_q <= word_total_d;
    end
  end

  assign locked     = locked_q;
  assign err_valid  = err_valid_q;
  assign err_bits   = err_bits_q;
  assign err_total  = err_total_q;
  assign word_total = word_total_q;
endmodule
`default_nettype wire

// File: tb/tb_m_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_m_seq_checker: vector table, corner sequences and random stream vs model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module tb_m_seq_checker;
  localparam int LOCK_CNT    = 4;
  localparam int LOSS_THRESH = 8;
  localparam int NW          = 640;

  logic        clk;
  logic        rst;
  logic [31:0] Signal_Recv;
  logic        recv_valid;
  logic        clr_cnt;
  logic        locked;
  logic        err_valid;
  logic [5:0]  err_bits;
  logic [31:0] err_total;
  logic [31:0] word_total;

  m_seq_checker #(.DATA_WIDTH(32), .LOCK_CNT(LOCK_CNT), .LOSS_THRESH(LOSS_THRESH)) dut (
    .clk         (clk),
    .rst         (rst),
    .Signal_Recv (Signal_Recv),
    .recv_valid  (recv_valid),
    .clr_cnt     (clr_cnt),
    .locked      (locked),
    .err_valid   (err_valid),
    .err_bits    (err_bits),
    .err_total   (err_total),
    .word_total  (word_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Clean PRBS15 stream: b[n] = b[n-15] ^ b[n-14], history seeded with all ones
  bit          sb[0:15+32*NW-1];
  logic [31:0] clean[0:NW-1];

  // Reference model state
  int          m_mode;   // 0 hunt, 1 verify, 2 locked
  logic [14:0] m_h;      // last 15 sequence bits, bit 0 most recent
  int          m_good, m_wsum, m_wcnt;
  bit          m_locked, m_ev;
  logic [5:0]  m_eb;
  longint      m_etot, m_wtot;

  typedef struct {
    int          widx;
    logic [31:0] flip;
    bit          valid;
    bit          clr;
    bit          e_locked;
    bit          e_ev;
    logic [5:0]  e_eb;
    logic [31:0] e_etot;
    logic [31:0] e_wtot;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [31:0] m_predict(input logic [14:0] h);
    bit q[$];
    bit nb;
    logic [31:0] w;
    for (int i = 14; i >= 0; i--) q.push_back(h[i]);
    for (int k = 0; k < 32; k++) begin
      nb = q[q.size()-15] ^ q[q.size()-14];
      q.push_back(nb);
      w[31-k] = nb;
    end
    return w;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_h = '0; m_good = 0; m_wsum = 0; m_wcnt = 0;
    m_locked = 0; m_ev = 0; m_eb = '0; m_etot = 0; m_wtot = 0;
  endtask

  task automatic model_step(input logic [31:0] w, input bit v, input bit c);
    logic [31:0] pw;
    int e;
    m_ev = 0;
    if (v) begin
      pw = m_predict(m_h);
      e  = $countones(w ^ pw);
      if (m_mode == 0) begin
        if (w[14:0] != 0) begin m_h = w[14:0]; m_mode = 1; m_good = 0; end
      end else if (m_mode == 1) begin
        m_ev = 1; m_eb = 6'(e);
        if (e == 0) begin
          m_h = pw[14:0]; m_good++;
          if (m_good == LOCK_CNT) begin m_mode = 2; m_locked = 1; m_wsum = 0; m_wcnt = 0; end
        end else if (w[14:0] != 0) begin
          m_h = w[14:0]; m_good = 0;
        end else begin
          m_mode = 0;
        end
      end else begin
        m_ev = 1; m_eb = 6'(e); m_h = pw[14:0];
        m_wtot = m_wtot + 1; if (m_wtot > 64'hFFFF_FFFF) m_wtot = 64'hFFFF_FFFF;
        m_etot = m_etot + e; if (m_etot > 64'hFFFF_FFFF) m_etot = 64'hFFFF_FFFF;
        m_wsum += e; m_wcnt++;
        if (m_wsum >= LOSS_THRESH) begin m_mode = 0; m_locked = 0; m_wsum = 0; m_wcnt = 0; end
        else if (m_wcnt == 16) begin m_wsum = 0; m_wcnt = 0; end
      end
    end
    if (c) begin m_etot = 0; m_wtot = 0; end
  endtask

  task automatic drive(input logic [31:0] w, input bit v, input bit c);
    @(negedge clk);
    Signal_Recv = w; recv_valid = v; clr_cnt = c;
    @(posedge clk);
    model_step(w, v, c);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_locked"}, 32'(locked), 32'(m_locked));
    chk({tag, "_err_valid"}, 32'(err_valid), 32'(m_ev));
    chk({tag, "_err_bits"}, 32'(err_bits), 32'(m_eb));
    chk({tag, "_err_total"}, err_total, m_etot[31:0]);
    chk({tag, "_word_total"}, word_total, m_wtot[31:0]);
  endtask

  // Asserts reset away from a clock edge and checks outputs clear without a clock
  task automatic do_reset(input string tag);
    rst = 1'b1; recv_valid = 1'b0; clr_cnt = 1'b0;
    #2;
    model_reset();
    check_model(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic lock_up(input int base);
    for (int k = 0; k < 5; k++) drive(clean[base+k], 1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 15; i++) sb[i] = 1'b1;
    for (int n = 15; n < 15 + 32*NW; n++) sb[n] = sb[n-15] ^ sb[n-14];
    for (int k = 0; k < NW; k++)
      for (int j = 0; j < 32; j++) clean[k][31-j] = sb[15+32*k+j];

    //          widx flip          v  c  lk ev eb etot wtot
    tbl[0]  = '{0, 32'h0,          1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 32'h0,          1, 0, 0, 1, 0, 0, 0};
    tbl[2]  = '{2, 32'h0,          1, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{3, 32'h0,          1, 0, 0, 1, 0, 0, 0};
    tbl[4]  = '{4, 32'h0,          1, 0, 1, 1, 0, 0, 0};
    tbl[5]  = '{5, 32'h0,          0, 0, 1, 0, 0, 0, 0};
    tbl[6]  = '{5, 32'h8001_0004,  1, 0, 1, 1, 3, 3, 1};
    tbl[7]  = '{6, 32'h0,          1, 0, 1, 1, 0, 3, 2};
    tbl[8]  = '{7, 32'h0,          1, 1, 1, 1, 0, 0, 0};
    tbl[9]  = '{8, 32'h0000_0100,  1, 1, 1, 1, 1, 0, 0};
    tbl[10] = '{9, 32'h0,          1, 0, 1, 1, 0, 0, 1};

    rst = 1'b0; recv_valid = 1'b0; clr_cnt = 1'b0; Signal_Recv = '0;
    #1;
    do_reset("reset0");

    for (int i = 0; i < 11; i++) begin
      drive(clean[tbl[i].widx] ^ tbl[i].flip, tbl[i].valid, tbl[i].clr);
      chk($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].e_locked));
      chk($sformatf("tbl%0d_err_valid", i), 32'(err_valid), 32'(tbl[i].e_ev));
      chk($sformatf("tbl%0d_err_bits", i), 32'(err_bits), 32'(tbl[i].e_eb));
      chk($sformatf("tbl%0d_err_total", i), err_total, tbl[i].e_etot);
      chk($sformatf("tbl%0d_word_total", i), word_total, tbl[i].e_wtot);
    end

    // Loss of lock after 8 single-bit errors, relock after LOCK_CNT+1 clean words
    do_reset("reset_a");
    lock_up(0);
    chk("lossA_locked_before", 32'(locked), 32'd1);
    for (int k = 0; k < 8; k++) begin
      drive(clean[5+k] ^ (32'd1 << ((3*k) % 32)), 1, 0);
      chk($sformatf("lossA_err%0d_locked", k), 32'(locked), (k == 7) ? 32'd0 : 32'd1);
      check_model($sformatf("lossA_err%0d", k));
    end
    for (int k = 0; k < 5; k++) begin
      drive(clean[13+k], 1, 0);
      chk($sformatf("lossA_relock%0d", k), 32'(locked), (k == 4) ? 32'd1 : 32'd0);
    end

    // Error in the 2nd verify word reseeds from that word
    do_reset("reset_b");
    drive(clean[0], 1, 0);
    drive(clean[1], 1, 0);
    drive(clean[2] ^ 32'h8000_0000, 1, 0);
    chk("verB_err_valid", 32'(err_valid), 32'd1);
    chk("verB_err_bits", 32'(err_bits), 32'd1);
    chk("verB_locked", 32'(locked), 32'd0);
    for (int k = 3; k <= 6; k++) begin
      drive(clean[k], 1, 0);
      chk($sformatf("verB_word%0d_locked", k), 32'(locked), (k == 6) ? 32'd1 : 32'd0);
    end

    // All-zero words never leave hunt; a zero-LSB seed is ignored too
    do_reset("reset_c");
    for (int k = 0; k < 20; k++) begin
      drive(32'h0, 1, 0);
      chk($sformatf("zeroC_%0d_err_valid", k), 32'(err_valid), 32'd0);
      chk($sformatf("zeroC_%0d_locked", k), 32'(locked), 32'd0);
    end
    drive(32'hFFFF_8000, 1, 0);
    drive(clean[0], 1, 0);
    chk("zeroC_seedskip_err_valid", 32'(err_valid), 32'd0);
    for (int k = 1; k <= 4; k++) drive(clean[k], 1, 0);
    chk("zeroC_lock", 32'(locked), 32'd1);

    // Async reset while locked, then normal relock
    drive(clean[5], 1, 0);
    chk("rstD_err_valid_pre", 32'(err_valid), 32'd1);
    do_reset("rstD_mid");
    lock_up(20);
    chk("rstD_relock", 32'(locked), 32'd1);
    chk("rstD_word_total", word_total, 32'd0);

    // Randomized stream against the model
    do_reset("reset_r");
    begin
      int idx = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        bit v, c;
        int r;
        logic [31:0] w;
        v = ($urandom_range(0, 3) != 0);
        c = ($urandom_range(0, 39) == 0);
        w = clean[idx % NW];
        r = $urandom_range(0, 99);
        if (r < 8) w = w ^ (32'd1 << $urandom_range(0, 31));
        else if (r < 11) begin
          for (int b = 0; b < 3; b++) w = w ^ (32'd1 << $urandom_range(0, 31));
        end else if (r < 12) w = $urandom;
        if (v) idx++;
        drive(w, v, c);
        check_model($sformatf("rand%0d", cyc));
        if (cyc == 300) do_reset("rand_rst");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
